// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring divide on operand magnitudes.
// Latency 33 cycles from the start edge (1 cycle for divide-by-zero/overflow); holds the pipeline via stall_req.
module ex_muldiv #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            funct3,
  input  logic [XLEN-1:0]       op1,
  input  logic [XLEN-1:0]       op2,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic                  flush,
  output logic                  stall_req,
  output logic                  done,
  output logic [XLEN-1:0]       result,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o
);

  localparam int              CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t                  r_state;
  logic [1:0]              r_f3;
  logic [XLEN-1:0]         r_hi, r_lo, r_mc;
  logic                    r_neg;
  logic [CW-1:0]           r_cnt;
  logic                    r_done, r_wreg, r_wreg_lat;
  logic [XLEN-1:0]         r_result;
  logic [REG_ADDR_W-1:0]   r_wd;

  logic                    w_s1, w_s2, w_neg_a, w_neg_b, w_neg, w_div0, w_ovf;
  logic [XLEN-1:0]         w_a, w_b, w_spec_res;
  logic [XLEN:0]           w_sum, w_sh, w_diff;
  logic                    w_ge;
  logic [XLEN-1:0]         w_nhi, w_nlo, w_dsel, w_dres, w_mres, w_fin;
  logic [2*XLEN-1:0]       w_prod, w_sprod;

  // Operand signedness: MULHU/DIVU/REMU treat op1 unsigned; MULHSU additionally treats op2 unsigned.
  assign w_s1    = funct3[2] ? ~funct3[0] : ~(funct3[1] & funct3[0]);
  assign w_s2    = funct3[2] ? ~funct3[0] : ~funct3[1];
  assign w_neg_a = w_s1 & op1[XLEN-1];
  assign w_neg_b = w_s2 & op2[XLEN-1];
  assign w_a     = w_neg_a ? -op1 : op1;
  assign w_b     = w_neg_b ? -op2 : op2;
  assign w_neg   = (funct3[2] & funct3[1]) ? w_neg_a : (w_neg_a ^ w_neg_b);

  assign w_div0     = funct3[2] & (op2 == '0);
  assign w_ovf      = funct3[2] & ~funct3[0] & (op1 == MIN_NEG) & (op2 == '1);
  assign w_spec_res = w_div0 ? (funct3[1] ? op1 : '1) : (funct3[1] ? '0 : op1);

  // One multiply step: add multiplicand when multiplier LSB set, shift {acc, multiplier} right.
  assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mc} : '0);
  // One restoring-divide step: shift next dividend bit into the partial remainder and trial-subtract.
  assign w_sh   = {r_hi, r_lo[XLEN-1]};
  assign w_diff = w_sh - {1'b0, r_mc};
  assign w_ge   = ~w_diff[XLEN];

  assign w_nhi  = (r_state == S_DIV) ? (w_ge ? w_diff[XLEN-1:0] : w_sh[XLEN-1:0]) : w_sum[XLEN:1];
  assign w_nlo  = (r_state == S_DIV) ? {r_lo[XLEN-2:0], w_ge} : {w_sum[0], r_lo[XLEN-1:1]};

  assign w_prod  = {w_nhi, w_nlo};
  assign w_sprod = r_neg ? -w_prod : w_prod;
  assign w_mres  = (r_f3 == 2'b00) ? w_sprod[XLEN-1:0] : w_sprod[2*XLEN-1:XLEN];
  assign w_dsel  = r_f3[1] ? w_nhi : w_nlo;
  assign w_dres  = r_neg ? -w_dsel : w_dsel;
  assign w_fin   = (r_state == S_DIV) ? w_dres : w_mres;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_f3       <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_mc       <= '0;
      r_neg      <= 1'b0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_wreg     <= 1'b0;
      r_wreg_lat <= 1'b0;
      r_result   <= '0;
      r_wd       <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
      r_wreg  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          r_wreg <= 1'b0;
          if (start) begin
            r_f3       <= funct3[1:0];
            r_wd       <= wd_i;
            r_wreg_lat <= wreg_i;
            r_neg      <= w_neg;
            r_cnt      <= '0;
            r_hi       <= '0;
            if (w_div0 | w_ovf) begin
              r_result <= w_spec_res;
              r_done   <= 1'b1;
              r_wreg   <= wreg_i;
              r_state  <= S_DONE;
            end else if (funct3[2]) begin
              r_lo    <= w_a;
              r_mc    <= w_b;
              r_state <= S_DIV;
            end else begin
              r_lo    <= w_b;
              r_mc    <= w_a;
              r_state <= S_MUL;
            end
          end
        end
        S_MUL, S_DIV: begin
          r_hi <= w_nhi;
          r_lo <= w_nlo;
          if (r_cnt == CNT_LAST) begin
            r_cnt    <= '0;
            r_result <= w_fin;
            r_done   <= 1'b1;
            r_wreg   <= r_wreg_lat;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_wreg  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A flush landing in DONE must still kill the write-back in that same cycle.
  assign stall_req = rst & (((r_state == S_IDLE) & start & ~flush) | (r_state == S_MUL) | (r_state == S_DIV));
  assign done      = r_done & ~flush;
  assign wreg_o    = r_wreg & ~flush;
  assign result    = r_result;
  assign wd_o      = r_wd;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed RV32M cases, flush/reset scenarios and random ops
// compared against a plain-arithmetic reference model.
module tb_ex_muldiv;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, flush = 1'b0, wreg_i = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op1 = '0, op2 = '0;
  logic [4:0]  wd_i = '0;
  logic        stall_req, done, wreg_o;
  logic [31:0] result;
  logic [4:0]  wd_o;

  int n_chk = 0, n_pass = 0;
  bit mon_en = 0, mon_on = 0;
  int mon_k = 0, exp_lat = 0;
  logic [31:0] exp_res;
  logic [4:0]  exp_wd;
  logic        exp_we;
  bit          seen;

  ex_muldiv #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .op1(op1), .op2(op2),
    .wd_i(wd_i), .wreg_i(wreg_i), .flush(flush), .stall_req(stall_req), .done(done),
    .result(result), .wd_o(wd_o), .wreg_o(wreg_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  // RV32M semantics from 64-bit arithmetic; SV division truncates toward zero like RISC-V.
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (f)
      3'd0, 3'd1: p = 64'(sa * sb);
      3'd2:       p = 64'(sa * ub);
      3'd3:       p = {32'h0, a} * {32'h0, b};
      default:    p = '0;
    endcase
    if (!f[2]) return (f == 3'd0) ? p[31:0] : p[63:32];
    if (b == 32'h0) return f[1] ? a : 32'hFFFF_FFFF;
    case (f)
      3'd4:    return 32'(sa / sb);
      3'd5:    return 32'(ua / ub);
      3'd6:    return 32'(sa % sb);
      default: return 32'(ua % ub);
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 32'h0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Compare process: cycle k counts edges after the start edge (k=0 is the start cycle itself).
  always @(negedge clk) begin
    if (mon_en) begin
      if (mon_on) begin
        chk("stall_req", {31'h0, stall_req}, {31'h0, (mon_k < exp_lat)});
        chk("done", {31'h0, done}, {31'h0, (mon_k == exp_lat)});
        if (mon_k == exp_lat) begin
          chk("result", result, exp_res);
          chk("wd_o", {27'h0, wd_o}, {27'h0, exp_wd});
          chk("wreg_o", {31'h0, wreg_o}, {31'h0, exp_we});
        end
      end else begin
        chk("idle_done", {31'h0, done}, 32'h0);
        chk("idle_wreg", {31'h0, wreg_o}, 32'h0);
        chk("idle_stall", {31'h0, stall_req}, 32'h0);
      end
    end
  end

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wd, input logic we);
    @(posedge clk); #1;
    funct3 = f; op1 = a; op2 = b; wd_i = wd; wreg_i = we; start = 1'b1;
    exp_res = ref_res(f, a, b); exp_lat = ref_lat(f, a, b);
    exp_wd = wd; exp_we = we; mon_k = 0; mon_on = 1;
    @(posedge clk); #1;
    start = 1'b0; op1 = $urandom; op2 = $urandom; funct3 = 3'($urandom); wd_i = 5'($urandom); wreg_i = ~we;
    mon_k = 1;
    repeat (exp_lat) begin
      @(posedge clk); #1;
      mon_k++;
    end
    mon_on = 0;
  endtask

  logic [2:0]  d_f [11] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4};
  logic [31:0] d_a [11] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                            32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000};
  logic [31:0] d_b [11] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                            32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF};
  logic [31:0] d_r [11] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                            32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000};

  initial begin
    #2;
    chk("rst_stall", {31'h0, stall_req}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_wd", {27'h0, wd_o}, 32'h0);
    chk("rst_wreg", {31'h0, wreg_o}, 32'h0);
    #10 rst = 1'b1;

    // Pin the reference model with hand-computed values.
    for (int i = 0; i < 11; i++) chk("model_pin", ref_res(d_f[i], d_a[i], d_b[i]), d_r[i]);
    chk("model_lat_norm", 32'(ref_lat(3'd0, 32'd7, 32'hFFFF_FFFD)), 32'd33);
    chk("model_lat_spec", 32'(ref_lat(3'd5, 32'd5, 32'd0)), 32'd1);

    mon_en = 1;
    for (int i = 0; i < 11; i++) run_op(d_f[i], d_a[i], d_b[i], 5'(i + 3), 1'b1);

    // Flush in the middle of a divide: no done pulse, stall drops after the flush edge.
    mon_en = 0;
    @(posedge clk); #1;
    funct3 = 3'd4; op1 = 32'd1000; op2 = 32'd3; wd_i = 5'd9; wreg_i = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_cyc_stall", {31'h0, stall_req}, 32'h1);
    chk("flush_cyc_done", {31'h0, done}, 32'h0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("post_flush_stall", {31'h0, stall_req}, 32'h0);
    seen = 0;
    repeat (40) begin @(negedge clk); if (done || wreg_o || stall_req) seen = 1; end
    chk("flush_no_done", {31'h0, seen}, 32'h0);

    // Flush together with start: op is not accepted.
    @(posedge clk); #1;
    funct3 = 3'd0; op1 = 32'd3; op2 = 32'd4; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flush_start_stall", {31'h0, stall_req}, 32'h0);
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    seen = 0;
    repeat (36) begin @(negedge clk); if (done || stall_req) seen = 1; end
    chk("flush_start_no_op", {31'h0, seen}, 32'h0);

    // Flush in DONE suppresses done/wreg_o.
    @(posedge clk); #1;
    funct3 = 3'd5; op1 = 32'd5; op2 = 32'd0; wd_i = 5'd4; wreg_i = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("flush_done_done", {31'h0, done}, 32'h0);
    chk("flush_done_wreg", {31'h0, wreg_o}, 32'h0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("after_flush_done", {31'h0, done}, 32'h0);

    mon_en = 1;
    run_op(3'd4, 32'd1000, 32'd3, 5'd9, 1'b1);

    // Asynchronous reset mid-multiply.
    mon_en = 0;
    @(posedge clk); #1;
    funct3 = 3'd0; op1 = 32'd123; op2 = 32'd456; wd_i = 5'd17; wreg_i = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_stall", {31'h0, stall_req}, 32'h0);
    chk("arst_done", {31'h0, done}, 32'h0);
    chk("arst_result", result, 32'h0);
    chk("arst_wd", {27'h0, wd_o}, 32'h0);
    chk("arst_wreg", {31'h0, wreg_o}, 32'h0);
    @(posedge clk); #3 rst = 1'b1;
    mon_en = 1;
    run_op(3'd0, 32'd123, 32'd456, 5'd17, 1'b1);

    for (int n = 0; n < 150; n++) begin
      run_op(3'($urandom), pick_operand(), pick_operand(), 5'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    @(posedge clk); #1;
    mon_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
